// File: rtl/gpu_rect_fill_if.sv
// Command and framebuffer port-2 signals of the rectangle fill engine.
// The slave modport is the fill engine's view; master is the view of the
// surrounding system (command requester plus framebuffer port 2).
interface gpu_rect_fill_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [8:0] cmd_x;
  logic [7:0] cmd_y;
  logic [8:0] cmd_w;
  logic [7:0] cmd_h;
  logic       cmd_value;
  logic       cmd_xor;
  logic       busy;
  logic       done;
  logic [8:0] ram_x;
  logic [7:0] ram_y;
  logic       ram_enable_read;
  logic       ram_read_value;
  logic       ram_enable_write;
  logic       ram_write_value;

  modport slave (
    input  cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_value, cmd_xor,
    input  ram_read_value,
    output cmd_ready, busy, done,
    output ram_x, ram_y, ram_enable_read, ram_enable_write, ram_write_value
  );

  modport master (
    output cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_value, cmd_xor,
    output ram_read_value,
    input  cmd_ready, busy, done,
    input  ram_x, ram_y, ram_enable_read, ram_enable_write, ram_write_value
  );
endinterface

// File: rtl/gpu_rect_fill.sv
// Rectangle fill engine driving framebuffer port 2.
// Accepts one command, clips it to the screen, then writes every pixel of
// the rectangle in row-major order, one pixel per cycle.
// Optional feature macro: GPU_FILL_XOR_EN. When defined, a command with
// cmd_xor=1 does a read-modify-write per pixel (RD then WR) and writes
// old ^ value. When undefined, cmd_xor is ignored and no reads are issued.
module gpu_rect_fill #(
  parameter int WIDTH  = 320,
  parameter int HEIGHT = 200
) (
  input  logic           clk,
  input  logic           rst,
  gpu_rect_fill_if.slave bus
);

  localparam logic [9:0] WIDTH_C  = 10'(WIDTH);
  localparam logic [8:0] HEIGHT_C = 9'(HEIGHT);

`ifdef GPU_FILL_XOR_EN
  typedef enum logic [2:0] {S_IDLE, S_FILL, S_DONE, S_RD, S_WR} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_FILL, S_DONE} state_t;
`endif

  state_t     state_q, state_d;
  logic [8:0] x_q, x_d;
  logic [7:0] y_q, y_d;
  logic [8:0] xStart_q, xStart_d;
  logic [8:0] xLast_q, xLast_d;
  logic [7:0] yLast_q, yLast_d;
  logic       value_q, value_d;
`ifdef GPU_FILL_XOR_EN
  logic       xorMode_q, xorMode_d;
`endif

  logic [9:0] sumX, xEnd;
  logic [8:0] sumY, yEnd;
  logic [8:0] xLastNew;
  logic [7:0] yLastNew;
  logic       cmdEmpty;
  logic       lastCol;
  logic       lastPixel;

  // Clip the incoming command against the screen edge; the sums are one bit
  // wider than the coordinates so a rectangle hanging off the edge cannot wrap.
  always_comb begin
    sumX     = {1'b0, bus.cmd_x} + {1'b0, bus.cmd_w};
    sumY     = {1'b0, bus.cmd_y} + {1'b0, bus.cmd_h};
    xEnd     = (sumX > WIDTH_C)  ? WIDTH_C  : sumX;
    yEnd     = (sumY > HEIGHT_C) ? HEIGHT_C : sumY;
    cmdEmpty = ({1'b0, bus.cmd_x} >= xEnd) || ({1'b0, bus.cmd_y} >= yEnd);
    xLastNew = 9'(xEnd - 10'd1);
    yLastNew = 8'(yEnd - 9'd1);
    lastCol   = (x_q == xLast_q);
    lastPixel = lastCol && (y_q == yLast_q);
  end

  // State register and datapath registers; reset aborts any fill at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      x_q       <= '0;
      y_q       <= '0;
      xStart_q  <= '0;
      xLast_q   <= '0;
      yLast_q   <= '0;
      value_q   <= 1'b0;
`ifdef GPU_FILL_XOR_EN
      xorMode_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      xStart_q  <= xStart_d;
      xLast_q   <= xLast_d;
      yLast_q   <= yLast_d;
      value_q   <= value_d;
`ifdef GPU_FILL_XOR_EN
      xorMode_q <= xorMode_d;
`endif
    end
  end

  // Next-state logic: latch the command in IDLE, then walk the clipped
  // rectangle; the cursor x_q/y_q is the address presented to the framebuffer.
  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    xStart_d  = xStart_q;
    xLast_d   = xLast_q;
    yLast_d   = yLast_q;
    value_d   = value_q;
`ifdef GPU_FILL_XOR_EN
    xorMode_d = xorMode_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          xStart_d  = bus.cmd_x;
          xLast_d   = xLastNew;
          yLast_d   = yLastNew;
          value_d   = bus.cmd_value;
`ifdef GPU_FILL_XOR_EN
          xorMode_d = bus.cmd_xor;
`endif
          if (cmdEmpty) begin
            state_d = S_DONE;
          end else begin
            x_d = bus.cmd_x;
            y_d = bus.cmd_y;
`ifdef GPU_FILL_XOR_EN
            state_d = bus.cmd_xor ? S_RD : S_FILL;
`else
            state_d = S_FILL;
`endif
          end
        end
      end
      S_FILL: begin
        if (lastPixel) begin
          state_d = S_DONE;
        end else if (lastCol) begin
          x_d = xStart_q;
          y_d = y_q + 8'd1;
        end else begin
          x_d = x_q + 9'd1;
        end
      end
`ifdef GPU_FILL_XOR_EN
      S_RD: begin
        state_d = S_WR;
      end
      S_WR: begin
        if (lastPixel) begin
          state_d = S_DONE;
        end else begin
          state_d = S_RD;
          if (lastCol) begin
            x_d = xStart_q;
            y_d = y_q + 8'd1;
          end else begin
            x_d = x_q + 9'd1;
          end
        end
      end
`endif
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs decoded from the registered state; addresses come straight from
  // the cursor registers so they hold their last value while idle.
  always_comb begin
    bus.cmd_ready        = (state_q == S_IDLE);
    bus.done             = (state_q == S_DONE);
    bus.ram_x            = x_q;
    bus.ram_y            = y_q;
`ifdef GPU_FILL_XOR_EN
    bus.busy             = (state_q == S_FILL) || (state_q == S_RD) || (state_q == S_WR);
    bus.ram_enable_read  = (state_q == S_RD);
    bus.ram_enable_write = (state_q == S_FILL) || (state_q == S_WR);
    if (state_q == S_FILL) begin
      bus.ram_write_value = value_q;
    end else if (state_q == S_WR) begin
      bus.ram_write_value = bus.ram_read_value ^ value_q;
    end else begin
      bus.ram_write_value = 1'b0;
    end
`else
    bus.busy             = (state_q == S_FILL);
    bus.ram_enable_read  = 1'b0;
    bus.ram_enable_write = (state_q == S_FILL);
    bus.ram_write_value  = (state_q == S_FILL) ? value_q : 1'b0;
`endif
  end

`ifndef GPU_FILL_XOR_EN
  // Without read-modify-write the XOR request and read data have no consumer.
  logic unusedInputs;
  assign unusedInputs = bus.cmd_xor ^ bus.ram_read_value;
`endif

endmodule

// File: tb/tb_gpu_rect_fill.sv
// Self-checking bench for gpu_rect_fill: a scoreboard queue holds the writes
// each command must produce and a monitor pops them as the engine writes.
module tb_gpu_rect_fill;

  typedef struct packed {
    logic [8:0] x;
    logic [7:0] y;
    logic       v;
  } pix_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  pix_t sb[$];
  pix_t monExp;
  pix_t monGot;
  bit   fb [0:319][0:199];

  int rDone, rWrites, rFirstWr, rLastWr, rReads;
  bit rBusy;

  gpu_rect_fill_if bus ();

  gpu_rect_fill #(.WIDTH(320), .HEIGHT(200)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Framebuffer port 2 model: read data valid the cycle after a read.
  always @(posedge clk) begin
    if (!rst) begin
      if (bus.ram_enable_read) bus.ram_read_value <= fb[bus.ram_x][bus.ram_y];
      if (bus.ram_enable_write) fb[bus.ram_x][bus.ram_y] <= bus.ram_write_value;
    end
  end

  // Scoreboard monitor: every observed write must match the next queued pixel
  // and must lie on screen.
  always @(negedge clk) begin
    if (!rst && bus.ram_enable_write) begin
      monGot = '{x: bus.ram_x, y: bus.ram_y, v: bus.ram_write_value};
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_write got (%0d,%0d)=%0d required no write", monGot.x, monGot.y, monGot.v);
      end else begin
        monExp = sb.pop_front();
        if (monGot !== monExp) begin
          errors++;
          $display("[TB] FAIL write_pixel got (%0d,%0d)=%0d required (%0d,%0d)=%0d",
                   monGot.x, monGot.y, monGot.v, monExp.x, monExp.y, monExp.v);
        end
      end
      checks++;
      if (bus.ram_x >= 9'd320 || bus.ram_y >= 8'd200) begin
        errors++;
        $display("[TB] FAIL write_range got (%0d,%0d) required x<320 y<200", bus.ram_x, bus.ram_y);
      end
    end
  end

  // Queue every pixel of the clipped rectangle in row-major order.
  task automatic applyStimulus(input int x, input int y, input int w, input int h, input bit v);
    int xe, ye;
    xe = (x + w > 320) ? 320 : x + w;
    ye = (y + h > 200) ? 200 : y + h;
    for (int j = y; j < ye; j++)
      for (int i = x; i < xe; i++)
        sb.push_back('{x: 9'(i), y: 8'(j), v: v});
  endtask

  // Issue one command and observe cycles until done or the budget runs out.
  task automatic runCmd(input logic [8:0] x, input logic [7:0] y, input logic [8:0] w,
                        input logic [7:0] h, input bit v, input bit xr, input int budget);
    @(negedge clk);
    bus.cmd_x = x; bus.cmd_y = y; bus.cmd_w = w; bus.cmd_h = h;
    bus.cmd_value = v; bus.cmd_xor = xr; bus.cmd_valid = 1'b1;
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    rDone = -1; rWrites = 0; rFirstWr = -1; rLastWr = -1; rReads = 0; rBusy = 1'b0;
    for (int k = 1; k <= budget; k++) begin
      @(negedge clk);
      if (bus.ram_enable_write) begin
        rWrites++;
        if (rFirstWr < 0) rFirstWr = k;
        rLastWr = k;
      end
      if (bus.ram_enable_read) rReads++;
      if (bus.busy) rBusy = 1'b1;
      if (bus.done) begin
        rDone = k;
        break;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    checks++;
    if ({bus.cmd_ready, bus.busy, bus.done, bus.ram_enable_read, bus.ram_enable_write, bus.ram_write_value} !== 6'b100000) begin
      errors++;
      $display("[TB] FAIL reset_ctrl got %b required 100000",
               {bus.cmd_ready, bus.busy, bus.done, bus.ram_enable_read, bus.ram_enable_write, bus.ram_write_value});
    end
    checks++;
    if (bus.ram_x !== 9'd0 || bus.ram_y !== 8'd0) begin
      errors++;
      $display("[TB] FAIL reset_addr got (%0d,%0d) required (0,0)", bus.ram_x, bus.ram_y);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic_fill();
    applyStimulus(10, 5, 3, 2, 1'b1);
    runCmd(9'd10, 8'd5, 9'd3, 8'd2, 1'b1, 1'b0, 30);
    checks++;
    if (rFirstWr !== 1 || rLastWr !== 6 || rWrites !== 6) begin
      errors++;
      $display("[TB] FAIL basic_writes got first=%0d last=%0d n=%0d required 1 6 6", rFirstWr, rLastWr, rWrites);
    end
    checks++;
    if (rDone !== 7) begin
      errors++;
      $display("[TB] FAIL basic_done got %0d required 7", rDone);
    end
    checks++;
    if (sb.size() !== 0) begin
      errors++;
      $display("[TB] FAIL basic_leftover got %0d required 0", sb.size());
    end
  endtask

  task automatic test_clip();
    applyStimulus(318, 198, 5, 4, 1'b1);
    runCmd(9'd318, 8'd198, 9'd5, 8'd4, 1'b1, 1'b0, 30);
    checks++;
    if (rWrites !== 4 || rDone !== 5) begin
      errors++;
      $display("[TB] FAIL clip got n=%0d done=%0d required n=4 done=5", rWrites, rDone);
    end
    checks++;
    if (sb.size() !== 0) begin
      errors++;
      $display("[TB] FAIL clip_leftover got %0d required 0", sb.size());
    end
  endtask

  task automatic test_empty();
    runCmd(9'd40, 8'd40, 9'd0, 8'd3, 1'b1, 1'b0, 10);
    checks++;
    if (rWrites !== 0 || rDone !== 1 || rBusy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL empty_w0 got n=%0d done=%0d busy=%0d required 0 1 0", rWrites, rDone, rBusy);
    end
    runCmd(9'd400, 8'd10, 9'd5, 8'd5, 1'b1, 1'b0, 10);
    checks++;
    if (rWrites !== 0 || rDone !== 1 || rBusy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL empty_x400 got n=%0d done=%0d busy=%0d required 0 1 0", rWrites, rDone, rBusy);
    end
  endtask

  task automatic test_back_to_back();
    int doneA, readyAt, doneB, writesB;
    applyStimulus(0, 0, 2, 2, 1'b1);
    applyStimulus(5, 7, 1, 3, 1'b0);
    @(negedge clk);
    bus.cmd_x = 9'd0; bus.cmd_y = 8'd0; bus.cmd_w = 9'd2; bus.cmd_h = 8'd2;
    bus.cmd_value = 1'b1; bus.cmd_xor = 1'b0; bus.cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.cmd_x = 9'd5; bus.cmd_y = 8'd7; bus.cmd_w = 9'd1; bus.cmd_h = 8'd3; bus.cmd_value = 1'b0;
    doneA = -1; readyAt = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (bus.done) doneA = k;
      if (bus.cmd_ready) begin
        readyAt = k;
        break;
      end
    end
    checks++;
    if (doneA !== 5 || readyAt !== 6) begin
      errors++;
      $display("[TB] FAIL b2b_first got done=%0d ready=%0d required 5 6", doneA, readyAt);
    end
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    doneB = -1; writesB = 0;
    for (int k = 7; k <= 30; k++) begin
      @(negedge clk);
      if (bus.ram_enable_write) writesB++;
      if (bus.done) begin
        doneB = k;
        break;
      end
    end
    checks++;
    if (doneB !== 10 || writesB !== 3) begin
      errors++;
      $display("[TB] FAIL b2b_second got done=%0d n=%0d required 10 3", doneB, writesB);
    end
    checks++;
    if (sb.size() !== 0) begin
      errors++;
      $display("[TB] FAIL b2b_leftover got %0d required 0", sb.size());
    end
    @(negedge clk);
  endtask

  task automatic test_reset_midfill();
    bit sawDone, sawWrite;
    sb.push_back('{x: 9'd20, y: 8'd30, v: 1'b1});
    sb.push_back('{x: 9'd21, y: 8'd30, v: 1'b1});
    @(negedge clk);
    bus.cmd_x = 9'd20; bus.cmd_y = 8'd30; bus.cmd_w = 9'd4; bus.cmd_h = 8'd4;
    bus.cmd_value = 1'b1; bus.cmd_xor = 1'b0; bus.cmd_valid = 1'b1;
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    checks++;
    if (bus.ram_enable_write !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midreset_drop got we=%0d busy=%0d required 0 0", bus.ram_enable_write, bus.busy);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    sawDone = 1'b0; sawWrite = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.done) sawDone = 1'b1;
      if (bus.ram_enable_write) sawWrite = 1'b1;
    end
    checks++;
    if (sawDone !== 1'b0 || sawWrite !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midreset_quiet got done=%0d write=%0d required 0 0", sawDone, sawWrite);
    end
    checks++;
    if (bus.cmd_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL midreset_ready got %0d required 1", bus.cmd_ready);
    end
    checks++;
    if (sb.size() !== 0) begin
      errors++;
      $display("[TB] FAIL midreset_leftover got %0d required 0", sb.size());
    end
  endtask

`ifdef GPU_FILL_XOR_EN
  task automatic test_xor();
    fb[0][0] = 1'b1;
    fb[1][0] = 1'b0;
    sb.push_back('{x: 9'd0, y: 8'd0, v: 1'b0});
    sb.push_back('{x: 9'd1, y: 8'd0, v: 1'b1});
    runCmd(9'd0, 8'd0, 9'd2, 8'd1, 1'b1, 1'b1, 20);
    checks++;
    if (rReads !== 2 || rWrites !== 2 || rFirstWr !== 2 || rLastWr !== 4) begin
      errors++;
      $display("[TB] FAIL xor_cycles got rd=%0d wr=%0d first=%0d last=%0d required 2 2 2 4",
               rReads, rWrites, rFirstWr, rLastWr);
    end
    checks++;
    if (rDone !== 5) begin
      errors++;
      $display("[TB] FAIL xor_done got %0d required 5", rDone);
    end
    checks++;
    if (fb[0][0] !== 1'b0 || fb[1][0] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL xor_fb got (0,0)=%0d (1,0)=%0d required 0 1", fb[0][0], fb[1][0]);
    end
  endtask
`else
  task automatic test_xor_ignored();
    applyStimulus(50, 60, 2, 1, 1'b1);
    runCmd(9'd50, 8'd60, 9'd2, 8'd1, 1'b1, 1'b1, 20);
    checks++;
    if (rReads !== 0 || rWrites !== 2 || rDone !== 3) begin
      errors++;
      $display("[TB] FAIL xor_ignored got rd=%0d wr=%0d done=%0d required 0 2 3", rReads, rWrites, rDone);
    end
  endtask
`endif

  // Run every scenario in sequence and print the summary.
  initial begin
    checks = 0;
    errors = 0;
    bus.cmd_valid = 1'b0; bus.cmd_x = '0; bus.cmd_y = '0; bus.cmd_w = '0; bus.cmd_h = '0;
    bus.cmd_value = 1'b0; bus.cmd_xor = 1'b0; bus.ram_read_value = 1'b0;
    test_reset();
    test_basic_fill();
    test_clip();
    test_empty();
    test_back_to_back();
    test_reset_midfill();
`ifdef GPU_FILL_XOR_EN
    test_xor();
`else
    test_xor_ignored();
`endif
    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() !== 0) begin
      errors++;
      $display("[TB] FAIL final_leftover got %0d required 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gpu_rect_fill.md
Name: gpu_rect_fill

Overview:
- Rectangle fill engine that sits directly upstream of the dual-port 1-bit framebuffer's write port (port 2).
- Accepts one command with origin, size and colour, then sweeps the rectangle in row-major order, issuing one framebuffer write per pixel.
- Clips against the screen edge, so game logic (tetris blocks, clears, borders) never issues out-of-range addresses.
- Port 1 of the framebuffer stays with display scanout; this block owns port 2 exclusively.

Parameters:
- WIDTH, 320, screen width in pixels; x coordinates at or beyond it are clipped.
- HEIGHT, 200, screen height in pixels; y coordinates at or beyond it are clipped.

Ports:
- clk  in  1  system clock; the same clock drives framebuffer port 2.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE; a command is accepted when cmd_valid & cmd_ready.
- cmd_x  in  9  rectangle left column.
- cmd_y  in  8  rectangle top row.
- cmd_w  in  9  width in pixels; 0 = empty.
- cmd_h  in  8  height in pixels; 0 = empty.
- cmd_value  in  1  pixel colour to write.
- cmd_xor  in  1  XOR mode request; ignored unless GPU_FILL_XOR_EN is defined.
- busy  out  1  high from the cycle after acceptance until done is pulsed.
- done  out  1  one-cycle pulse when the command completes.
- ram_x  out  9  framebuffer port 2 x.
- ram_y  out  8  framebuffer port 2 y.
- ram_enable_read  out  1  framebuffer port 2 read enable.
- ram_read_value  in  1  framebuffer port 2 data; valid in the cycle after a read is issued.
- ram_enable_write  out  1  framebuffer port 2 write enable.
- ram_write_value  out  1  framebuffer port 2 write data.

Behaviour:
- Reset values: cmd_ready=1, busy=0, done=0, ram_enable_read=0, ram_enable_write=0, ram_x=0, ram_y=0, ram_write_value=0. State returns to IDLE.
- Reset asserted mid-fill aborts the command immediately. No done pulse; pixels already written stay written.
- State machine:
  - IDLE: on acceptance, register all command fields and compute the clipped end coordinates:
    - x_end = min(cmd_x + cmd_w, WIDTH), using a 10-bit sum.
    - y_end = min(cmd_y + cmd_h, HEIGHT), using a 9-bit sum.
  - If the clipped rectangle is empty (cmd_x >= x_end or cmd_y >= y_end), go to DONE. Otherwise go to FILL (or RD when XOR mode is active).
  - FILL: drive ram_x/ram_y with the current pixel, ram_enable_write=1, ram_write_value=value.
    - Advance x; at x_end-1, wrap x to cmd_x and increment y.
    - After the pixel (x_end-1, y_end-1), go to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE. busy drops in the same cycle done is high.
- Latency, plain mode:
  - Acceptance at cycle 0; first write at cycle 1.
  - Last write at cycle N, where N = clipped w*h.
  - done at cycle N+1; cmd_ready high again at cycle N+2.
  - Empty rectangle: done at cycle 1.
- Address outputs are registered. They hold the last driven value when idle. Enables are 0 outside active cycles.
- Commands presented while busy are not accepted (cmd_ready=0); the requester holds them.
- No write is ever issued with x >= WIDTH or y >= HEIGHT.

Optional Feature:
- Macro: GPU_FILL_XOR_EN.
- Defined: when cmd_xor=1 at acceptance, each pixel takes two cycles through states RD and WR.
  - RD: ram_enable_read=1 at the pixel address.
  - WR: same address, ram_enable_write=1, ram_write_value = ram_read_value ^ value.
  - Last write at cycle 2N; done at cycle 2N+1.
  - cmd_xor=0 behaves exactly as plain mode.
- Undefined: cmd_xor is ignored, the RD/WR states do not exist, and ram_enable_read is tied to 0.

Test Plan:
- Reset, then cmd (x=10, y=5, w=3, h=2, value=1): writes at (10,5),(11,5),(12,5),(10,6),(11,6),(12,6) on cycles 1-6; done at cycle 7; no other writes.
- cmd (x=318, y=198, w=5, h=4) -> clipped to 2x2; writes (318,198),(319,198),(318,199),(319,199) only; done at cycle 5.
- cmd with w=0, and separately cmd with x=400 -> zero writes; done at cycle 1; busy never high.
- Hold cmd_valid with a second command during the first fill: cmd_ready=0 until the cycle after done; second command accepted then and executed intact.
- Assert rst at cycle 3 of a 4x4 fill: write enables and busy drop immediately; no done; cmd_ready=1 after release.
- (GPU_FILL_XOR_EN) Framebuffer model pre-set with (0,0)=1 and (1,0)=0, then cmd (x=0, y=0, w=2, h=1, value=1, xor=1): read/write pairs on cycles 1-4; results (0,0)=0 and (1,0)=1; done at cycle 5.
